// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : UART transmitter with an internal circular FIFO. Frames are
//                start, LSB-first data, optional even parity, 1 or 2 stops.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx #(
    parameter int BaudRate     = 9600,
    parameter int ParityBit    = 0,
    parameter int DataBitsSize = 8,
    parameter int StopBits     = 1,
    parameter int BufferSize   = 64,
    parameter int ClockFreqHz  = 10000000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    output logic                          full,
    output logic                          empty,
    output logic                          overflow,
    output logic                          busy,
    output logic                          tx_sig,
    output logic [$clog2(BufferSize):0]   level
);

    localparam int SCLK_PERIOD = ClockFreqHz / BaudRate;
    localparam int CNT_W       = (SCLK_PERIOD > 1) ? $clog2(SCLK_PERIOD) : 1;
    localparam int PTR_W       = $clog2(BufferSize);
    localparam int LVL_W       = PTR_W + 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(SCLK_PERIOD - 1);
    localparam logic [2:0]       IDX_LAST  = 3'(DataBitsSize - 1);
    localparam logic             STOP_LAST = 1'(StopBits - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(BufferSize);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic             stop_cnt;
    logic [7:0]       shift;

    logic [7:0]       mem [BufferSize];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level_next;
    logic             push;
    logic             pop;
    logic             bit_end;

    // A full FIFO refuses the write even if a pop happens in the same cycle.
    assign push    = wr_en & ~full;
    assign pop     = (state == IDLE) & ~empty;
    assign bit_end = (cnt == BIT_LAST);

    // Next occupancy; simultaneous push and pop leave it unchanged.
    always_comb begin
        level_next = level;
        case ({push, pop})
            2'b10:   level_next = level + 1'b1;
            2'b01:   level_next = level - 1'b1;
            default: level_next = level;
        endcase
    end

    // Storage array, no reset needed since contents are qualified by level.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers and registered status flags derived from next level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level    <= level_next;
            empty    <= (level_next == '0);
            full     <= (level_next == LVL_FULL);
            overflow <= wr_en & full;
        end
    end

    // Frame sequencer; tx_sig is loaded with the bit of the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx_sig   <= 1'b1;
            busy     <= 1'b0;
            cnt      <= '0;
            idx      <= '0;
            stop_cnt <= 1'b0;
            shift    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx_sig <= 1'b1;
                    cnt    <= '0;
                    busy   <= 1'b0;
                    if (!empty) begin
                        shift  <= mem[rd_ptr];
                        state  <= START;
                        tx_sig <= 1'b0;
                        busy   <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt    <= '0;
                        idx    <= '0;
                        state  <= DATA;
                        tx_sig <= shift[0];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (idx == IDX_LAST) begin
                            if (ParityBit != 0) begin
                                state  <= PARITY;
                                tx_sig <= ^shift[DataBitsSize-1:0];
                            end else begin
                                state    <= STOP;
                                tx_sig   <= 1'b1;
                                stop_cnt <= 1'b0;
                            end
                        end else begin
                            idx    <= idx + 3'd1;
                            tx_sig <= shift[idx + 3'd1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        cnt      <= '0;
                        state    <= STOP;
                        tx_sig   <= 1'b1;
                        stop_cnt <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    tx_sig <= 1'b1;
                    if (bit_end) begin
                        cnt <= '0;
                        if (stop_cnt == STOP_LAST) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_sig <= 1'b1;
                    busy   <= 1'b0;
                    cnt    <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
